mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-port 512x12 program/data memory between two requesters.
  - Port A: Simplez CPU.
  - Port B: program loader / debug port, e.g. a serial bootloader writing 12-bit words.
- Sits between both requesters and the memory block. The memory samples address, write enable and data on the falling clock edge and registers data_out on that same falling edge.
- Grants one access per two clocks with round-robin fairness and a one-cycle ack pulse per completed access.

Parameters:
- AW, 9, memory address width (512 words).
- DW, 12, memory word width.

Ports:
- clk  input  1  system clock; all arbiter state is updated on the rising edge.
- rst  input  1  reset, asynchronous, active-high; one clock; no other clock domains.
- req_a  input  1  port A access request; held high until ack_a is seen.
- wr_a  input  1  port A write (1) / read (0); stable while req_a is high.
- addr_a  input  AW  port A address.
- wdata_a  input  DW  port A write data.
- ack_a  output  1  port A access complete; one-cycle pulse.
- rdata_a  output  DW  port A read data; valid only while ack_a=1.
- req_b, wr_b, addr_b, wdata_b, ack_b, rdata_b  same as the port A signals, for port B.
- mem_addr  output  AW  address to memory.
- mem_wr  output  1  write enable to memory.
- mem_din  output  DW  write data to memory.
- mem_dout  input  DW  memory data_out.

Behaviour:
- State machine: IDLE, BUSY. All outputs except rdata_* are registered.
- Reset (async, any time, including mid-access):
  - state=IDLE, ack_a=ack_b=0, mem_wr=0, mem_addr=0, mem_din=0.
  - last_grant=B, so port A wins the first contention.
  - An access interrupted by reset is abandoned with no ack.
  - A write already sampled by the memory on the preceding falling edge stays written.
- IDLE, rising edge:
  - No req: stay in IDLE; mem_wr=0.
  - Only one req: grant that port.
  - Both req: grant the port that is not last_grant (round-robin).
  - On grant, register:
    - mem_addr <= addr_x, mem_din <= wdata_x, mem_wr <= wr_x;
    - ack_x <= 1, owner <= x, last_grant <= x;
    - state <= BUSY.
- BUSY (exactly one cycle):
  - The memory executes the access on the falling edge inside this cycle. mem_dout is therefore valid before the next rising edge.
  - ack_owner=1 during this cycle.
  - rdata_a and rdata_b are driven combinationally from mem_dout.
  - Next rising edge: ack_*<=0, mem_wr<=0, state<=IDLE. req is not sampled in BUSY.
- Latency:
  - Request sampled at edge t0; ack and data are sampled by the requester at edge t1.
  - The requester updates or drops req at t1. The arbiter re-samples req at t2, so no duplicate access occurs.
  - Peak throughput: one access per 2 clocks.
- Write access:
  - ack pulses identically to a read.
  - rdata during that ack returns the OLD content of the word, because the memory reads before it writes on the same edge.
  - mem_wr is high for exactly one cycle per granted write.
- Fairness: with both req held continuously, grants alternate A,B,A,B,...
- Address and data pass straight through. Full 9-bit range 0..511 octal 0..0777; no wrap logic is needed.
- mem_addr and mem_din hold their last values in IDLE.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: port A (CPU) always wins contention. last_grant is not used. Port B is served only in IDLE cycles where req_a=0, and starvation of B is allowed.
- Undefined: round-robin as described under Behaviour.

Test Plan:
- After rst, req_a=1, wr_a=0, addr_a=0o002, with memory preloaded 0o002=0o7002:
  - ack_a=1 exactly one cycle after grant, rdata_a=0o7002;
  - ack_b=0 throughout;
  - mem_wr stays 0.
- Port B write, wr_b=1, addr_b=0o100, wdata_b=0o1234, then port B read of 0o100:
  - the write ack returns the old word;
  - the read returns 0o1234;
  - mem_wr is high for exactly 1 cycle.
- Both req held high for 8 accesses, A reading 0o003 and B reading 0o004:
  - acks alternate A,B,A,B;
  - rdata values 0o0003 and 0o0004 respectively.
- Same stimulus as the previous scenario with MEM_ARB_FIXED_PRIO_EN defined:
  - only ack_a pulses, every 2 cycles;
  - after req_a drops, B is granted on the next IDLE edge.
- Assert rst in the BUSY cycle of a port A write to 0o005 with data 0o7777:
  - ack_a=0 and mem_wr=0 immediately;
  - state returns to IDLE;
  - the first grant after reset release goes to A.
- Single-port back-to-back with req_a held high continuously:
  - exactly one ack every 2 cycles;
  - no two consecutive ack cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one falling-edge-sampled 512x12 memory between the CPU (A) and a loader/debug port (B).
// Define MEM_ARB_FIXED_PRIO_EN to give port A absolute priority instead of round-robin.
module mem_arbiter #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          wr_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          wr_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {PORT_A, PORT_B} port_t;

    state_t        state_q, state_d;
    port_t         last_grant_q, last_grant_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          grant_a, grant_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= PORT_B;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign grant_a = req_a;
    assign grant_b = req_b & ~req_a;
`else
    assign grant_a = req_a & (~req_b | (last_grant_q == PORT_B));
    assign grant_b = req_b & (~req_a | (last_grant_q == PORT_A));
`endif

    // Acks and write strobe default low so every grant yields exactly one pulse.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        mem_wr_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    mem_addr_d   = addr_a;
                    mem_din_d    = wdata_a;
                    mem_wr_d     = wr_a;
                    ack_a_d      = 1'b1;
                    last_grant_d = PORT_A;
                    state_d      = BUSY;
                end else if (grant_b) begin
                    mem_addr_d   = addr_b;
                    mem_din_d    = wdata_b;
                    mem_wr_d     = wr_b;
                    ack_b_d      = 1'b1;
                    last_grant_d = PORT_B;
                    state_d      = BUSY;
                end
            end
            BUSY: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ack_a    = ack_a_q;
    assign ack_b    = ack_b_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign rdata_a  = mem_dout;
    assign rdata_b  = mem_dout;

endmodule
